// File: rtl/ifetch_pkg.sv
// rtl/ifetch_pkg.sv - shared types and constants for the rv32i instruction fetch unit
// Contents:
//   INST_W, XLEN   instruction and address widths
//   NOP_INST       canonical rv32i nop (addi x0, x0, 0)
//   fetch_entry_t  buffered fetch result {pc, inst}
//   state_t        fetch FSM states {IDLE, RUN}
package ifetch_pkg;

  localparam int INST_W = 32;
  localparam int XLEN   = 32;

  localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/ifetch_fifo.sv
// rtl/ifetch_fifo.sv - circular instruction buffer holding fetched {pc, inst} entries
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   push       write entry at the tail (caller guarantees space)
//   entry      entry to write
//   pop        drop the head entry (ignored when empty)
//   flush      discard all entries; wins over push and pop
//   head       current head entry (content undefined while empty)
//   count      number of buffered entries
//   empty/full occupancy flags
module ifetch_fifo
  import ifetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  fetch_entry_t             entry,
  input  logic                     pop,
  input  logic                     flush,
  output fetch_entry_t             head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic          do_pop;

  assign do_pop = pop && (cnt != '0);

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (push && !do_pop) begin
        cnt <= cnt + CW'(1);
      end else if (!push && do_pop) begin
        cnt <= cnt - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= entry;
    end
  end

  assign head  = mem[rd_ptr];
  assign count = cnt;
  assign empty = (cnt == '0);
  assign full  = (cnt == CW'(DEPTH));

endmodule

// File: rtl/ifetch_unit.sv
// rtl/ifetch_unit.sv - rv32i instruction fetch initiator with redirect flush and decode buffer
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   fetch_en        allow new fetch requests
//   imem_req/addr   fetch request and word-aligned byte address (held until imem_ready)
//   imem_rdata      returned instruction word, valid with imem_ready
//   imem_ready      single-cycle response strobe
//   redirect_valid  redirect fetch to redirect_pc (branch, jump, trap); flushes the buffer
//   redirect_pc     redirect target, low two bits ignored
//   inst_valid      buffered instruction available to decode
//   inst_ready      decode takes the head instruction
//   inst_data/pc    head instruction and its PC (hold the last head while empty)
module ifetch_unit
  import ifetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_en,
  output logic [XLEN-1:0]   imem_addr,
  output logic              imem_req,
  input  logic [INST_W-1:0] imem_rdata,
  input  logic              imem_ready,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst_data,
  output logic [XLEN-1:0]   inst_pc
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_t          state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] redirect_target;
  logic            accept;
  logic            pop;
  logic            push;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_next;
  fetch_entry_t    push_entry;
  fetch_entry_t    head;
  fetch_entry_t    held;
  logic            empty;
  logic            full;
  logic            unused_redirect_lsb;

  assign redirect_target     = {redirect_pc[XLEN-1:2], 2'b00};
  assign unused_redirect_lsb = ^redirect_pc[1:0];

  // A response that coincides with a redirect belongs to the old stream.
  assign accept     = imem_ready && !redirect_valid;
  assign inst_valid = !empty;
  assign pop        = inst_valid && inst_ready;
  assign push       = accept && (!full || pop);
  assign push_entry = {pc, imem_rdata};

  always_comb begin
    count_next = count;
    if (redirect_valid) begin
      count_next = '0;
    end else begin
      count_next = count + {{(CW-1){1'b0}}, accept} - {{(CW-1){1'b0}}, pop};
    end
  end

  // Requesting only while the post-cycle occupancy leaves a free slot means
  // every sampled request already owns buffer space for its response.
  assign imem_req = (state == RUN) && fetch_en && (count_next < CW'(FIFO_DEPTH));

  // Showing pc+4 in the accept cycle lets a single-cycle memory stream one
  // word per clock without re-fetching the word just returned.
  always_comb begin
    imem_addr = pc;
    if (redirect_valid) begin
      imem_addr = redirect_target;
    end else if (accept) begin
      imem_addr = pc + 32'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (fetch_en) state <= RUN;
        RUN:     if (!fetch_en) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (redirect_valid) begin
      pc <= redirect_target;
    end else if (accept) begin
      pc <= pc + 32'd4;
    end
  end

  // Shadow of the visible head so decode sees a stable value while empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      held <= '0;
    end else if (!empty) begin
      held <= head;
    end
  end

  assign inst_data = empty ? held.inst : head.inst;
  assign inst_pc   = empty ? held.pc   : head.pc;

  ifetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .entry (push_entry),
    .pop   (pop),
    .flush (redirect_valid),
    .head  (head),
    .count (count),
    .empty (empty),
    .full  (full)
  );

endmodule

// File: tb/tb_ifetch_unit.sv
// tb/tb_ifetch_unit.sv - self-checking bench for ifetch_unit against a queue-based fetch model
module tb_ifetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_en;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;

  always #5 clk = ~clk;

  ifetch_unit #(
    .RESET_PC   (RESET_PC),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .fetch_en       (fetch_en),
    .imem_addr      (imem_addr),
    .imem_req       (imem_req),
    .imem_rdata     (imem_rdata),
    .imem_ready     (imem_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc)
  );

  int total;
  int bad;
  int cyc;

  // reference model: pc, enable state, buffer as a queue of {pc, inst}
  logic [31:0] m_pc;
  bit          m_run;
  logic [63:0] m_q[$];
  logic [63:0] m_last;

  // memory responder
  int          mem_lat;
  int          mem_cnt;
  bit          mem_pend;
  logic [31:0] mem_raddr;

  // observations of the last ticked cycle
  logic        t_req;
  logic        t_valid;
  logic [31:0] t_addr;
  logic [31:0] pop_log[$];
  logic [31:0] pop_data_log[$];

  function automatic logic [31:0] rom(input logic [31:0] a);
    return (a << 8) | 32'h0000_0013;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    logic        e_acc;
    logic        e_valid;
    logic        e_pop;
    logic        e_req;
    int          e_cnt;
    logic [31:0] e_addr;
    logic [31:0] e_tgt;
    logic [63:0] e_head;
    bit          pend_n;
    @(negedge clk);
    e_tgt   = {redirect_pc[31:2], 2'b00};
    e_acc   = imem_ready && !redirect_valid;
    e_valid = (m_q.size() > 0);
    e_head  = e_valid ? m_q[0] : m_last;
    e_pop   = e_valid && inst_ready;
    e_cnt   = redirect_valid ? 0 : (int'(m_q.size()) + int'(e_acc) - int'(e_pop));
    e_req   = m_run && fetch_en && (e_cnt < DEPTH);
    e_addr  = redirect_valid ? e_tgt : (e_acc ? m_pc + 32'd4 : m_pc);
    t_req   = imem_req;
    t_valid = inst_valid;
    t_addr  = imem_addr;
    if (!rst) begin
      chk("req",   imem_req,   e_req);
      chk("addr",  imem_addr,  e_addr);
      chk("valid", inst_valid, e_valid);
      chk("data",  inst_data,  e_head[31:0]);
      chk("pc",    inst_pc,    e_head[63:32]);
      if (inst_valid && inst_ready) begin
        pop_log.push_back(inst_pc);
        pop_data_log.push_back(inst_data);
      end
    end
    @(posedge clk);
    if (rst) begin
      m_pc   = RESET_PC;
      m_run  = 1'b0;
      m_q.delete();
      m_last = '0;
    end else begin
      if (e_valid) m_last = m_q[0];
      m_run = fetch_en;
      if (redirect_valid) begin
        m_q.delete();
        m_pc = e_tgt;
      end else begin
        if (e_pop) void'(m_q.pop_front());
        if (e_acc) begin
          m_q.push_back({m_pc, imem_rdata});
          m_pc = m_pc + 32'd4;
        end
      end
    end
    pend_n = 1'b0;
    if (rst || !t_req) begin
      mem_cnt = 0;
    end else begin
      mem_cnt++;
      if (mem_cnt >= mem_lat) begin
        pend_n    = 1'b1;
        mem_raddr = t_addr;
        mem_cnt   = 0;
      end
    end
    mem_pend = pend_n;
    cyc++;
    #1;
    imem_ready = mem_pend;
    imem_rdata = mem_pend ? rom(mem_raddr) : $urandom();
  endtask

  task automatic do_reset(input int lat);
    mem_lat        = lat;
    rst            = 1'b1;
    fetch_en       = 1'b0;
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    repeat (2) tick();
    rst = 1'b0;
    pop_log.delete();
    pop_data_log.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cycle=%0d got=running want=finished", cyc);
    $fatal(1);
  end

  initial begin
    int first_req;
    int first_valid;
    int stale;
    logic [31:0] last_pc;
    total = 0; bad = 0; cyc = 0;
    m_pc = RESET_PC; m_run = 1'b0; m_last = '0;
    mem_cnt = 0; mem_pend = 1'b0; mem_raddr = '0;
    imem_ready = 1'b0; imem_rdata = '0;

    // reset values, then streaming with a single-cycle memory
    do_reset(1);
    #1;
    chk("rst_req",   imem_req,   32'd0);
    chk("rst_valid", inst_valid, 32'd0);
    chk("rst_addr",  imem_addr,  32'h0);
    chk("rst_data",  inst_data,  32'h0);
    chk("rst_pc",    inst_pc,    32'h0);
    fetch_en = 1'b1; inst_ready = 1'b1;
    first_req = -1; first_valid = -1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (t_req && first_req < 0) first_req = i;
      if (t_valid && first_valid < 0) first_valid = i;
    end
    chk("first_req_cycle",   first_req,   32'd1);
    chk("first_valid_cycle", first_valid, 32'd3);
    chk("stream_pops", pop_log.size() >= 3, 32'd1);
    if (pop_log.size() >= 3) begin
      chk("stream_pc0", pop_log[0], 32'h0);
      chk("stream_pc1", pop_log[1], 32'h4);
      chk("stream_pc2", pop_log[2], 32'h8);
      chk("stream_d0", pop_data_log[0], 32'h0000_0013);
      chk("stream_d1", pop_data_log[1], 32'h0000_0413);
      chk("stream_d2", pop_data_log[2], 32'h0000_0813);
    end

    // decode stall: buffer fills, requests stop, order kept on resume
    do_reset(1);
    fetch_en = 1'b1; inst_ready = 1'b0;
    repeat (12) tick();
    chk("stall_req",   t_req,   32'd0);
    chk("stall_valid", t_valid, 32'd1);
    inst_ready = 1'b1;
    repeat (6) tick();
    chk("resume_pops", pop_log.size() >= 3, 32'd1);
    if (pop_log.size() >= 3) begin
      chk("resume_pc0", pop_log[0], 32'h0);
      chk("resume_pc1", pop_log[1], 32'h4);
      chk("resume_pc2", pop_log[2], 32'h8);
    end

    // redirect in the same cycle as a response
    do_reset(1);
    fetch_en = 1'b1; inst_ready = 1'b1;
    repeat (5) tick();
    for (int k = 0; k < 20 && !imem_ready; k++) tick();
    chk("redir_ready_seen", imem_ready, 32'd1);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
    tick();
    redirect_valid = 1'b0;
    pop_log.delete(); pop_data_log.delete();
    tick();
    chk("redir_flushed", t_valid, 32'd0);
    repeat (6) tick();
    if (pop_log.size() > 0) begin
      chk("redir_pc",   pop_log[0],      32'h0000_0100);
      chk("redir_data", pop_data_log[0], 32'h0001_0013);
    end else begin
      chk("redir_pops", 32'd0, 32'd1);
    end

    // three-cycle memory, redirect while a request is counting
    do_reset(3);
    fetch_en = 1'b1; inst_ready = 1'b1;
    repeat (10) tick();
    for (int k = 0; k < 20 && mem_cnt != 1; k++) tick();
    chk("lat3_midcount", mem_cnt, 32'd1);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
    tick();
    redirect_valid = 1'b0;
    pop_log.delete(); pop_data_log.delete();
    repeat (20) tick();
    stale = 0;
    foreach (pop_log[i]) if (pop_log[i] !== 32'h100 + 32'(4 * i)) stale++;
    chk("lat3_stale", stale, 32'd0);
    if (pop_log.size() > 0) begin
      chk("lat3_pc",   pop_log[0],      32'h0000_0100);
      chk("lat3_data", pop_data_log[0], 32'h0001_0013);
    end else begin
      chk("lat3_pops", 32'd0, 32'd1);
    end

    // fetch_en drop with a response in flight, then resume
    do_reset(1);
    fetch_en = 1'b1; inst_ready = 1'b1;
    repeat (8) tick();
    pop_log.delete(); pop_data_log.delete();
    fetch_en = 1'b0;
    repeat (6) tick();
    chk("drop_req", t_req, 32'd0);
    chk("drop_delivered", pop_log.size() > 0, 32'd1);
    last_pc = (pop_log.size() > 0) ? pop_log[pop_log.size()-1] : 32'hDEAD_BEEF;
    pop_log.delete(); pop_data_log.delete();
    fetch_en = 1'b1;
    repeat (6) tick();
    if (pop_log.size() > 0) chk("resume_next_pc", pop_log[0], last_pc + 32'd4);
    else chk("resume_pops", 32'd0, 32'd1);

    // address wrap at the top of the space, then reset mid-stream
    do_reset(1);
    fetch_en = 1'b1; inst_ready = 1'b1;
    repeat (4) tick();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE;
    tick();
    redirect_valid = 1'b0;
    pop_log.delete(); pop_data_log.delete();
    tick();
    chk("wrap_addr", t_addr, 32'h0000_0000);
    repeat (5) tick();
    if (pop_log.size() >= 2) begin
      chk("wrap_pc0", pop_log[0], 32'hFFFF_FFFC);
      chk("wrap_pc1", pop_log[1], 32'h0000_0000);
    end else begin
      chk("wrap_pops", pop_log.size(), 32'd2);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    chk("midrst_valid", t_valid, 32'd0);
    chk("midrst_addr",  t_addr,  RESET_PC);

    // randomized traffic per memory latency
    for (int lat = 1; lat <= 3; lat++) begin
      do_reset(lat);
      for (int n = 0; n < 1500; n++) begin
        fetch_en       = ($urandom_range(0, 15) != 0);
        inst_ready     = ($urandom_range(0, 3) != 0);
        redirect_valid = ($urandom_range(0, 19) == 0);
        redirect_pc    = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15))
                                                     : 32'($urandom());
        rst            = ($urandom_range(0, 299) == 0);
        tick();
      end
      rst = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
